// File: rtl/axi4_wr_arbiter.sv
// Two-requester AXI4 write-channel arbiter onto one target port.
// Round-robin grant; one transaction owns the target from grant until B handshake.
module axi4_wr_arbiter #(
    parameter int ID_WIDTH = 4,
    parameter int DWIDTH   = 64
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    // requester 0
    input  logic [ID_WIDTH-1:0]   M0_AWID,
    input  logic [31:0]           M0_AWADDR,
    input  logic [7:0]            M0_AWLEN,
    input  logic [2:0]            M0_AWSIZE,
    input  logic [1:0]            M0_AWBURST,
    input  logic                  M0_AWVALID,
    output logic                  M0_AWREADY,
    input  logic [DWIDTH-1:0]     M0_WDATA,
    input  logic [DWIDTH/8-1:0]   M0_WSTRB,
    input  logic                  M0_WLAST,
    input  logic                  M0_WVALID,
    output logic                  M0_WREADY,
    output logic [ID_WIDTH-1:0]   M0_BID,
    output logic [1:0]            M0_BRESP,
    output logic                  M0_BVALID,
    input  logic                  M0_BREADY,
    // requester 1
    input  logic [ID_WIDTH-1:0]   M1_AWID,
    input  logic [31:0]           M1_AWADDR,
    input  logic [7:0]            M1_AWLEN,
    input  logic [2:0]            M1_AWSIZE,
    input  logic [1:0]            M1_AWBURST,
    input  logic                  M1_AWVALID,
    output logic                  M1_AWREADY,
    input  logic [DWIDTH-1:0]     M1_WDATA,
    input  logic [DWIDTH/8-1:0]   M1_WSTRB,
    input  logic                  M1_WLAST,
    input  logic                  M1_WVALID,
    output logic                  M1_WREADY,
    output logic [ID_WIDTH-1:0]   M1_BID,
    output logic [1:0]            M1_BRESP,
    output logic                  M1_BVALID,
    input  logic                  M1_BREADY,
    // shared target
    output logic [ID_WIDTH-1:0]   S_AWID,
    output logic [31:0]           S_AWADDR,
    output logic [7:0]            S_AWLEN,
    output logic [2:0]            S_AWSIZE,
    output logic [1:0]            S_AWBURST,
    output logic                  S_AWVALID,
    input  logic                  S_AWREADY,
    output logic [DWIDTH-1:0]     S_WDATA,
    output logic [DWIDTH/8-1:0]   S_WSTRB,
    output logic                  S_WLAST,
    output logic                  S_WVALID,
    input  logic                  S_WREADY,
    input  logic [ID_WIDTH-1:0]   S_BID,
    input  logic [1:0]            S_BRESP,
    input  logic                  S_BVALID,
    output logic                  S_BREADY,
    output logic                  PROT_ERR,
    output logic                  GRANT
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t      state;
    logic        last_grant;
    logic [7:0]  beat_limit;
    logic [7:0]  beat_cnt;
    logic        winner;
    logic        g_wlast;
    logic        g_bready;

    // On a tie the requester not granted last wins; otherwise whoever asks.
    always_comb begin
        if (M0_AWVALID && M1_AWVALID) winner = ~last_grant;
        else                          winner = M1_AWVALID;
    end

    assign g_wlast  = GRANT ? M1_WLAST  : M0_WLAST;
    assign g_bready = GRANT ? M1_BREADY : M0_BREADY;

    always_comb begin
        S_AWID     = '0;
        S_AWADDR   = '0;
        S_AWLEN    = '0;
        S_AWSIZE   = '0;
        S_AWBURST  = '0;
        S_AWVALID  = 1'b0;
        S_WDATA    = '0;
        S_WSTRB    = '0;
        S_WLAST    = 1'b0;
        S_WVALID   = 1'b0;
        S_BREADY   = 1'b0;
        M0_AWREADY = 1'b0;
        M1_AWREADY = 1'b0;
        M0_WREADY  = 1'b0;
        M1_WREADY  = 1'b0;
        M0_BID     = '0;
        M0_BRESP   = '0;
        M0_BVALID  = 1'b0;
        M1_BID     = '0;
        M1_BRESP   = '0;
        M1_BVALID  = 1'b0;
        case (state)
            ADDR: begin
                S_AWID     = GRANT ? M1_AWID    : M0_AWID;
                S_AWADDR   = GRANT ? M1_AWADDR  : M0_AWADDR;
                S_AWLEN    = GRANT ? M1_AWLEN   : M0_AWLEN;
                S_AWSIZE   = GRANT ? M1_AWSIZE  : M0_AWSIZE;
                S_AWBURST  = GRANT ? M1_AWBURST : M0_AWBURST;
                S_AWVALID  = GRANT ? M1_AWVALID : M0_AWVALID;
                M0_AWREADY = ~GRANT & S_AWREADY;
                M1_AWREADY =  GRANT & S_AWREADY;
            end
            DATA: begin
                S_WDATA   = GRANT ? M1_WDATA  : M0_WDATA;
                S_WSTRB   = GRANT ? M1_WSTRB  : M0_WSTRB;
                S_WVALID  = GRANT ? M1_WVALID : M0_WVALID;
                S_WLAST   = (beat_cnt == beat_limit);
                M0_WREADY = ~GRANT & S_WREADY;
                M1_WREADY =  GRANT & S_WREADY;
            end
            RESP: begin
                S_BREADY = g_bready;
                if (GRANT) begin
                    M1_BID    = S_BID;
                    M1_BRESP  = S_BRESP;
                    M1_BVALID = S_BVALID;
                end else begin
                    M0_BID    = S_BID;
                    M0_BRESP  = S_BRESP;
                    M0_BVALID = S_BVALID;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state      <= IDLE;
            GRANT      <= 1'b0;
            last_grant <= 1'b1;
            beat_limit <= '0;
            beat_cnt   <= '0;
            PROT_ERR   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (M0_AWVALID || M1_AWVALID) begin
                    GRANT      <= winner;
                    beat_limit <= winner ? M1_AWLEN : M0_AWLEN;
                    state      <= ADDR;
                end
                ADDR: if (S_AWVALID && S_AWREADY) begin
                    beat_cnt <= '0;
                    state    <= DATA;
                end
                // Counter may wrap after beat 255; S_WLAST has already ended the burst.
                DATA: if (S_WVALID && S_WREADY) begin
                    beat_cnt <= beat_cnt + 8'd1;
                    if (g_wlast != S_WLAST) PROT_ERR <= 1'b1;
                    if (S_WLAST) state <= RESP;
                end
                RESP: if (S_BVALID && S_BREADY) begin
                    last_grant <= GRANT;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_wr_arbiter.sv
// Bench for axi4_wr_arbiter: vector table, fixed corner sequences and random
// transactions checked against a round-robin / sticky-error reference model.
module tb_axi4_wr_arbiter;

    localparam int IDW = 4;
    localparam int DW  = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             areset;
    logic [IDW-1:0]   awid    [2];
    logic [31:0]      awaddr  [2];
    logic [7:0]       awlen   [2];
    logic [2:0]       awsize  [2];
    logic [1:0]       awburst [2];
    logic [1:0]       awvalid;
    logic [1:0]       awready;
    logic [DW-1:0]    wdata   [2];
    logic [DW/8-1:0]  wstrb   [2];
    logic [1:0]       wlast;
    logic [1:0]       wvalid;
    logic [1:0]       wready;
    logic [IDW-1:0]   m0_bid, m1_bid;
    logic [1:0]       m0_bresp, m1_bresp;
    logic [1:0]       bvalid;
    logic [1:0]       bready;

    logic [IDW-1:0]   s_awid;
    logic [31:0]      s_awaddr;
    logic [7:0]       s_awlen;
    logic [2:0]       s_awsize;
    logic [1:0]       s_awburst;
    logic             s_awvalid, s_awready;
    logic [DW-1:0]    s_wdata;
    logic [DW/8-1:0]  s_wstrb;
    logic             s_wlast, s_wvalid, s_wready;
    logic [IDW-1:0]   s_bid;
    logic [1:0]       s_bresp;
    logic             s_bvalid, s_bready;
    logic             prot_err, gnt;

    axi4_wr_arbiter #(.ID_WIDTH(IDW), .DWIDTH(DW)) dut (
        .ACLK(clk), .ARESET(areset),
        .M0_AWID(awid[0]), .M0_AWADDR(awaddr[0]), .M0_AWLEN(awlen[0]),
        .M0_AWSIZE(awsize[0]), .M0_AWBURST(awburst[0]), .M0_AWVALID(awvalid[0]),
        .M0_AWREADY(awready[0]),
        .M0_WDATA(wdata[0]), .M0_WSTRB(wstrb[0]), .M0_WLAST(wlast[0]),
        .M0_WVALID(wvalid[0]), .M0_WREADY(wready[0]),
        .M0_BID(m0_bid), .M0_BRESP(m0_bresp), .M0_BVALID(bvalid[0]), .M0_BREADY(bready[0]),
        .M1_AWID(awid[1]), .M1_AWADDR(awaddr[1]), .M1_AWLEN(awlen[1]),
        .M1_AWSIZE(awsize[1]), .M1_AWBURST(awburst[1]), .M1_AWVALID(awvalid[1]),
        .M1_AWREADY(awready[1]),
        .M1_WDATA(wdata[1]), .M1_WSTRB(wstrb[1]), .M1_WLAST(wlast[1]),
        .M1_WVALID(wvalid[1]), .M1_WREADY(wready[1]),
        .M1_BID(m1_bid), .M1_BRESP(m1_bresp), .M1_BVALID(bvalid[1]), .M1_BREADY(bready[1]),
        .S_AWID(s_awid), .S_AWADDR(s_awaddr), .S_AWLEN(s_awlen), .S_AWSIZE(s_awsize),
        .S_AWBURST(s_awburst), .S_AWVALID(s_awvalid), .S_AWREADY(s_awready),
        .S_WDATA(s_wdata), .S_WSTRB(s_wstrb), .S_WLAST(s_wlast), .S_WVALID(s_wvalid),
        .S_WREADY(s_wready),
        .S_BID(s_bid), .S_BRESP(s_bresp), .S_BVALID(s_bvalid), .S_BREADY(s_bready),
        .PROT_ERR(prot_err), .GRANT(gnt)
    );

    int n_checks = 0;
    int n_err    = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: last winner index and sticky protocol-error flag.
    int mdl_last;
    bit mdl_prot;

    function automatic int mdl_pick(bit r0, bit r1);
        if (r0 && r1) return 1 - mdl_last;
        return r1 ? 1 : 0;
    endfunction

    task automatic mdl_reset();
        mdl_last = 1;
        mdl_prot = 1'b0;
    endtask

    task automatic clear_inputs();
        awvalid = '0; wvalid = '0; wlast = '0; bready = '0;
        s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0;
        s_bid = '0; s_bresp = '0;
        for (int i = 0; i < 2; i++) begin
            wdata[i] = '0; wstrb[i] = '0;
        end
    endtask

    task automatic check_quiet(string tag);
        check({tag, "_s_awvalid"}, s_awvalid, 0);
        check({tag, "_s_wvalid"},  s_wvalid, 0);
        check({tag, "_s_bready"},  s_bready, 0);
        check({tag, "_m_ready_valid"}, {awready, wready, bvalid}, 0);
        check({tag, "_s_awaddr"},  s_awaddr, 0);
        check({tag, "_s_wdata"},   s_wdata, 0);
    endtask

    // Called at a negedge while the DUT is IDLE; request is sampled at the next posedge.
    task automatic start_req(bit r0, bit r1, logic [7:0] l0, logic [7:0] l1);
        awlen[0] = l0; awlen[1] = l1;
        awvalid  = {r1, r0};
    endtask

    // Runs the granted requester's transaction through ADDR, DATA and RESP.
    task automatic serve(int g, bit bad, bit toggle, bit gaps, bit hold);
        int o;
        int k;
        int cyc;
        bit done;
        bit loser_rdy;
        logic [7:0] len;
        logic [DW-1:0] cur_d;
        logic [DW/8-1:0] cur_s;
        o = 1 - g;
        len = awlen[g];
        loser_rdy = 1'b0;

        @(negedge clk);
        s_awready = 1'b1;
        #1;
        check("aw_valid_latency", s_awvalid, 1);
        check("grant", gnt, g);
        check("aw_addr", s_awaddr, awaddr[g]);
        check("aw_len", s_awlen, len);
        check("aw_id", s_awid, awid[g]);
        check("aw_size_burst", {s_awsize, s_awburst}, {awsize[g], awburst[g]});
        check("aw_ready_grant", awready[g], 1);
        if (awready[o]) loser_rdy = 1'b1;

        @(negedge clk);
        s_awready = 1'b0;
        awvalid[g] = 1'b0;
        if (!hold) awvalid[o] = 1'b0;
        k = 0; cyc = 0; done = 1'b0;
        cur_d = {$urandom(), $urandom()};
        cur_s = DW/8'($urandom_range(0, 255));
        while (!done && cyc < 3000) begin
            wvalid[g] = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            wdata[g]  = cur_d;
            wstrb[g]  = cur_s;
            wlast[g]  = bad ? (len != 0 && k == 0) : (k == int'(len));
            s_wready  = toggle ? cyc[0] : 1'b1;
            #1;
            if (awready[o] || wready[o]) loser_rdy = 1'b1;
            check("w_ready_pass", wready[g], s_wready);
            check("w_valid_pass", s_wvalid, wvalid[g]);
            if (s_wvalid && s_wready) begin
                check("w_data", s_wdata, cur_d);
                check("w_strb", s_wstrb, cur_s);
                check("w_last_gen", s_wlast, k == int'(len));
                if (s_wlast) done = 1'b1;
                k++;
                cur_d = {$urandom(), $urandom()};
                cur_s = DW/8'($urandom_range(0, 255));
            end
            @(negedge clk);
            cyc++;
        end
        check("beats", k, int'(len) + 1);

        wvalid[g] = 1'b0; wlast[g] = 1'b0; s_wready = 1'b0;
        s_bvalid = 1'b1;
        s_bresp  = 2'($urandom_range(0, 3));
        s_bid    = awid[g];
        bready[g] = 1'b1;
        #1;
        check("b_valid", bvalid[g], 1);
        check("b_id", g ? m1_bid : m0_bid, awid[g]);
        check("b_resp", g ? m1_bresp : m0_bresp, s_bresp);
        check("s_bready", s_bready, 1);
        if (bvalid[o] || awready[o]) loser_rdy = 1'b1;
        check("loser_no_ready", loser_rdy, 0);

        @(negedge clk);
        s_bvalid = 1'b0; bready = '0;
        #1;
        check_quiet("idle");
    endtask

    task automatic run_txn(bit r0, bit r1, logic [7:0] l0, logic [7:0] l1,
                           bit bad, bit toggle, bit gaps, bit hold, int exp_g);
        start_req(r0, r1, l0, l1);
        serve(exp_g, bad, toggle, gaps, hold);
        mdl_last = exp_g;
        mdl_prot = mdl_prot | bad;
        check("prot_err", prot_err, mdl_prot);
    endtask

    typedef struct {
        bit         r0;
        bit         r1;
        logic [7:0] len0;
        logic [7:0] len1;
        bit         bad;
        bit         toggle;
        int         exp_g;
        bit         exp_prot;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b1, 1'b0, 8'd3,   8'd0, 1'b0, 1'b0, 0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 8'd2,   8'd5, 1'b0, 1'b0, 1, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 8'd5,   8'd2, 1'b0, 1'b0, 0, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 8'd0,   8'd0, 1'b0, 1'b1, 1, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 8'd255, 8'd0, 1'b0, 1'b1, 0, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 8'd0,   8'd1, 1'b1, 1'b0, 1, 1'b1};
        tbl[6] = '{1'b1, 1'b1, 8'd4,   8'd4, 1'b0, 1'b0, 0, 1'b1};
        tbl[7] = '{1'b1, 1'b1, 8'd1,   8'd3, 1'b0, 1'b1, 1, 1'b1};

        awid[0] = 4'h3; awid[1] = 4'hA;
        awaddr[0] = 32'h0000_0100; awaddr[1] = 32'h0000_2040;
        awsize[0] = 3'd3; awsize[1] = 3'd2;
        awburst[0] = 2'd1; awburst[1] = 2'd2;
        awlen[0] = '0; awlen[1] = '0;
        clear_inputs();
        mdl_reset();
        areset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_quiet("reset");
        check("reset_prot", prot_err, 0);
        check("reset_grant", gnt, 0);
        areset = 1'b0;
        @(negedge clk);

        foreach (tbl[i]) begin
            run_txn(tbl[i].r0, tbl[i].r1, tbl[i].len0, tbl[i].len1,
                    tbl[i].bad, tbl[i].toggle, 1'b0, 1'b0, tbl[i].exp_g);
            check("tbl_prot", prot_err, tbl[i].exp_prot);
        end

        // Simultaneous requests for three rounds, loser keeps AWVALID high throughout.
        run_txn(1'b1, 1'b1, 8'd2, 8'd3, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        run_txn(1'b1, 1'b1, 8'd2, 8'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        run_txn(1'b1, 1'b1, 8'd2, 8'd3, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        awvalid = '0;

        for (int i = 0; i < 30; i++) begin
            int unsigned r;
            logic [7:0] l0, l1;
            bit bad, tog, gaps;
            int eg;
            r    = $urandom_range(1, 3);
            l0   = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 7));
            l1   = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 7));
            bad  = ($urandom_range(0, 9) == 0);
            tog  = $urandom_range(0, 1) != 0;
            gaps = $urandom_range(0, 1) != 0;
            eg   = mdl_pick(r[0], r[1]);
            run_txn(r[0], r[1], l0, l1, bad, tog, gaps, 1'b0, eg);
        end

        // Make sure the error flag is set and M0 was last winner before the reset.
        run_txn(1'b1, 1'b0, 8'd1, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 0);

        // Reset in the middle of an M1 burst, after two of four beats.
        start_req(1'b0, 1'b1, 8'd0, 8'd3);
        @(negedge clk);
        s_awready = 1'b1;
        #1;
        check("rst_seq_grant", gnt, 1);
        @(negedge clk);
        s_awready = 1'b0; awvalid = '0;
        wvalid[1] = 1'b1; wlast[1] = 1'b0; s_wready = 1'b1;
        repeat (2) @(negedge clk);
        areset = 1'b1;
        awvalid = 2'b11; s_awready = 1'b1; s_bvalid = 1'b1; bready = 2'b11;
        @(negedge clk);
        #1;
        check_quiet("mid_reset");
        check("mid_reset_prot", prot_err, 0);
        check("mid_reset_grant", gnt, 0);
        areset = 1'b0;
        clear_inputs();
        mdl_reset();
        run_txn(1'b1, 1'b1, 8'd2, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/axi4_wr_arbiter.md
AXI4_WR_ARBITER -- requirements
Module: axi4_wr_arbiter

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 4, AXI ID width on all ports.
REQ-002 SHALL have parameter DWIDTH, default 64, write data width; DWIDTH/8 strobe bits.
REQ-003 SHALL have port ACLK, input, 1, single clock; all logic on rising edge.
REQ-004 SHALL have port ARESET, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have ports Mn_AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID, input, ID_WIDTH/32/8/3/2/1 (n=0,1): requester write address.
REQ-006 SHALL have port Mn_AWREADY, output, 1 (n=0,1): address accept to requester n.
REQ-007 SHALL have ports Mn_WDATA/WSTRB/WLAST/WVALID, input, DWIDTH/DWIDTH/8/1/1 (n=0,1): requester write data.
REQ-008 SHALL have port Mn_WREADY, output, 1 (n=0,1): data accept to requester n.
REQ-009 SHALL have ports Mn_BID/BRESP/BVALID, output, ID_WIDTH/2/1, and Mn_BREADY, input, 1 (n=0,1): response to requester n.
REQ-010 SHALL have ports S_AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID, output, and S_AWREADY, input: shared target address channel.
REQ-011 SHALL have ports S_WDATA/WSTRB/WLAST/WVALID, output, and S_WREADY, input: shared target data channel.
REQ-012 SHALL have ports S_BID/BRESP/BVALID, input, and S_BREADY, output: shared target response channel.
REQ-013 SHALL have port PROT_ERR, output, 1: sticky requester WLAST mismatch flag.
REQ-014 SHALL have port GRANT, output, 1: index of requester currently owning the port (valid outside IDLE).

Function
REQ-015 SHALL implement FSM states IDLE, ADDR, DATA, RESP; one write transaction owns the target from grant until B handshake.
REQ-016 In IDLE, any Mn_AWVALID high SHALL select a winner, latch GRANT, capture that requester's AWLEN into a beat limit, and move to ADDR next cycle (1-cycle arbitration latency).
REQ-017 Arbitration SHALL be round-robin: on a tie, the requester not granted last wins; after reset M0 wins the first tie.
REQ-018 In ADDR, S_AW* SHALL equal the granted requester's AW* combinationally; Mgrant_AWREADY = S_AWREADY; on S_AWVALID&S_AWREADY go to DATA.
REQ-019 In DATA, S_WDATA/WSTRB/WVALID SHALL mux from the granted requester; Mgrant_WREADY = S_WREADY.
REQ-020 An 8-bit beat counter SHALL clear on entering DATA and increment per W handshake; S_WLAST SHALL be 1 exactly when counter equals the latched AWLEN.
REQ-021 The W handshake with S_WLAST high SHALL move the FSM to RESP; the requester's WLAST is not forwarded.
REQ-022 PROT_ERR SHALL set on any W handshake where requester WLAST differs from generated S_WLAST, and hold until ARESET.
REQ-023 In RESP, S_BID/BRESP/BVALID SHALL route to the granted requester; S_BREADY = Mgrant_BREADY; on handshake go to IDLE and record GRANT as last winner.
REQ-024 Non-granted requester and all states other than the listed channel phase SHALL see AWREADY, WREADY, BVALID = 0; S_AWVALID=0 outside ADDR, S_WVALID=0 outside DATA, S_BREADY=0 outside RESP.
REQ-025 A requester raising AWVALID while the other owns the port SHALL wait with no ready; its request is evaluated on the next IDLE cycle.
REQ-026 AWLEN=0 SHALL produce a single beat with S_WLAST=1; AWLEN=255 SHALL produce 256 beats without counter overflow affecting termination.
REQ-027 Unused S_* data/address outputs outside their phase SHALL drive 0.

Reset
REQ-028 ARESET high at a rising edge SHALL force state IDLE, GRANT=0, last-winner so M0 wins the next tie, beat counter 0, PROT_ERR 0, and all valid/ready outputs 0, including mid-burst.

Verification
REQ-029 M0 only, AWADDR=0x100, AWLEN=3 -> S_AWVALID one cycle after M0_AWVALID, 4 W beats, S_WLAST on beat 4 only, M0_BVALID with S_BRESP, FSM back to IDLE.
REQ-030 M0 and M1 request same cycle, three back-to-back rounds -> grant order M0, M1, M0; loser sees AWREADY=0 until IDLE.
REQ-031 M1 AWLEN=1 but asserts WLAST on beat 1 -> S_WLAST only on beat 2, PROT_ERR=1 and stays 1 through later clean transactions.
REQ-032 AWLEN=0 and AWLEN=255 bursts with S_WREADY toggling every other cycle -> exactly 1 and 256 beats forwarded, no data dropped.
REQ-033 ARESET asserted in DATA after 2 of 4 beats -> next cycle all valids/readies 0, PROT_ERR 0, then fresh M1-vs-M0 tie grants M0.
